// File: rtl/mult_arbiter.sv
// Round-robin arbiter and sequencer that shares one serial multiplier among NREQ requesters.
// Launches the multiplier, supervises it with a watchdog and returns the product as a one-cycle response.

module mult_arbiter #(
  parameter int N       = 16,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_A,
  input  logic [NREQ*N-1:0] req_B,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [2*N-1:0]    rsp_prod,
  output logic              rsp_err,
  output logic              busy,
  output logic              mul_start,
  output logic [N-1:0]      mul_A,
  output logic [N-1:0]      mul_B,
  input  logic              mul_end,
  input  logic [2*N-1:0]    mul_produto
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic [PW-1:0]     ptr_r;
  logic [PW-1:0]     gnt_r;
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     cnt_inc_s;
  logic              timeout_s;
  logic              win_found_s;
  logic [PW-1:0]     win_idx_s;
  logic              accept_s;
  logic [N-1:0]      mul_a_r;
  logic [N-1:0]      mul_b_r;
  logic [2*N-1:0]    prod_r;
  logic              err_r;
  logic              mul_start_r;
  logic              busy_r;
  logic [NREQ-1:0]   rsp_valid_r;
  logic [NREQ-1:0]   req_ready_s;

  // Requester index base+k, wrapped modulo NREQ (k is always below NREQ).
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    return PW'((s >= NREQ) ? (s - NREQ) : s);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin winner search; descending k so the nearest request above ptr wins.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      win_idx_s   = req_valid[wrap_add(ptr_r, k)] ? wrap_add(ptr_r, k) : win_idx_s;
      win_found_s = win_found_s | req_valid[wrap_add(ptr_r, k)];
    end
  end

  assign accept_s  = (state_r == IDLE) && win_found_s;
  assign cnt_inc_s = cnt_r + CW'(1);
  assign timeout_s = (cnt_inc_s == CW'(TIMEOUT));

  // Accept handshake is offered only while idle.
  always_comb begin
    req_ready_s = '0;
    if (accept_s) begin
      req_ready_s = onehot(win_idx_s);
    end else begin
      req_ready_s = '0;
    end
  end

  // Next-state logic; a completion beats a simultaneous watchdog expiry.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = START;
        end else begin
          state_nx_s = IDLE;
        end
      end
      START: state_nx_s = WAIT;
      WAIT: begin
        if (mul_end || timeout_s) begin
          state_nx_s = RESP;
        end else begin
          state_nx_s = WAIT;
        end
      end
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Grant bookkeeping, operand capture, watchdog and result capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_r   <= '0;
      gnt_r   <= '0;
      cnt_r   <= '0;
      mul_a_r <= '0;
      mul_b_r <= '0;
      prod_r  <= '0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mul_a_r <= req_A[int'(win_idx_s)*N +: N];
            mul_b_r <= req_B[int'(win_idx_s)*N +: N];
            gnt_r   <= win_idx_s;
            ptr_r   <= wrap_add(win_idx_s, 1);
          end
        end
        START: cnt_r <= '0;
        WAIT: begin
          if (cnt_r != CW'(TIMEOUT)) begin
            cnt_r <= cnt_inc_s;
          end
          if (mul_end) begin
            prod_r <= mul_produto;
            err_r  <= 1'b0;
          end else if (timeout_s) begin
            prod_r <= '0;
            err_r  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Control outputs registered from the next state so they align with START/RESP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mul_start_r <= 1'b0;
      busy_r      <= 1'b0;
      rsp_valid_r <= '0;
    end else begin
      mul_start_r <= (state_nx_s == START);
      busy_r      <= (state_nx_s != IDLE);
      rsp_valid_r <= (state_nx_s == RESP) ? onehot(gnt_r) : '0;
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_prod  = prod_r;
  assign rsp_err   = err_r;
  assign busy      = busy_r;
  assign mul_start = mul_start_r;
  assign mul_A     = mul_a_r;
  assign mul_B     = mul_b_r;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed-vector bench for mult_arbiter with a behavioural serial-multiplier model
// whose latency (or hang) is set per operation.

module tb_mult_arbiter;

  localparam int N       = 16;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_A;
  logic [NREQ*N-1:0] req_B;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [2*N-1:0]    rsp_prod;
  logic              rsp_err;
  logic              busy;
  logic              mul_start;
  logic [N-1:0]      mul_A;
  logic [N-1:0]      mul_B;
  logic              mul_end;
  logic [2*N-1:0]    mul_produto;

  int n_vec = 0;
  int n_err = 0;
  int mdl_lat = 1;
  bit mdl_never = 1'b0;
  int mdl_cnt;

  mult_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_A(req_A), .req_B(req_B), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_prod(rsp_prod), .rsp_err(rsp_err), .busy(busy),
    .mul_start(mul_start), .mul_A(mul_A), .mul_B(mul_B),
    .mul_end(mul_end), .mul_produto(mul_produto)
  );

  initial forever #5 clock = ~clock;

  // Multiplier model: mul_end is high in the lat-th cycle after the start cycle.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mul_end     <= 1'b0;
      mul_produto <= 32'd0;
      mdl_cnt     <= 0;
    end else if (mul_start) begin
      mul_produto <= {16'd0, mul_A} * {16'd0, mul_B};
      if (mdl_never) begin
        mdl_cnt <= 0;
        mul_end <= 1'b0;
      end else begin
        mdl_cnt <= mdl_lat - 1;
        mul_end <= (mdl_lat == 1);
      end
    end else if (mdl_cnt > 0) begin
      mdl_cnt <= mdl_cnt - 1;
      mul_end <= (mdl_cnt == 1);
    end else begin
      mul_end <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // One operation by requester r while the requesters in hold stay valid.
  task automatic run_op(input int r, input logic [15:0] a, input logic [15:0] b,
                        input int lat, input bit never, input logic [3:0] hold);
    logic [3:0]  sel;
    logic [31:0] ep;
    logic        ee;
    int          el;
    int          cyc;
    int          starts;
    sel = 4'b0001 << r;
    if (never || lat > TIMEOUT) begin
      ep = 32'd0;
      ee = 1'b1;
      el = TIMEOUT + 1;
    end else begin
      ep = {16'd0, a} * {16'd0, b};
      ee = 1'b0;
      el = lat + 1;
    end
    mdl_lat       = lat;
    mdl_never     = never;
    req_A[r*N +: N] = a;
    req_B[r*N +: N] = b;
    req_valid     = hold | sel;
    #1;
    chk("req_ready", 64'(req_ready), 64'(sel));
    tick;
    req_valid = hold;
    chk("mul_start", 64'(mul_start), 64'd1);
    chk("mul_A", 64'(mul_A), 64'(a));
    chk("mul_B", 64'(mul_B), 64'(b));
    chk("busy", 64'(busy), 64'd1);
    cyc    = 0;
    starts = 0;
    while (rsp_valid == 4'b0000 && cyc < 300) begin
      tick;
      cyc++;
      if (mul_start) starts++;
    end
    chk("rsp_latency", 64'(cyc), 64'(el));
    chk("rsp_valid", 64'(rsp_valid), 64'(sel));
    chk("rsp_prod", 64'(rsp_prod), 64'(ep));
    chk("rsp_err", 64'(rsp_err), 64'(ee));
    chk("extra_start", 64'(starts), 64'd0);
    tick;
    chk("rsp_pulse_end", 64'(rsp_valid), 64'd0);
  endtask

  logic [15:0] rr_a [8];
  logic [15:0] rr_b [8];

  initial begin
    int silent;
    reset     = 1'b0;
    req_valid = 4'b0000;
    req_A     = 64'd0;
    req_B     = 64'd0;
    rr_a = '{16'h0003, 16'h0100, 16'hFFFF, 16'h1234, 16'h00FF, 16'h8000, 16'h0007, 16'hABCD};
    rr_b = '{16'h0005, 16'h0100, 16'h0002, 16'h0000, 16'h00FF, 16'h0002, 16'h0009, 16'h0001};
    repeat (3) tick;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mul_start", 64'(mul_start), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_prod", 64'(rsp_prod), 64'd0);
    chk("rst_mul_A", 64'(mul_A), 64'd0);
    reset = 1'b1;
    tick;
    chk("idle_ready", 64'(req_ready), 64'd0);

    // Single request.
    run_op(2, 16'h1234, 16'h0010, 17, 1'b0, 4'b0000);

    // Round robin: all four valid at every arbitration; ptr starts at 3 here.
    for (int k = 0; k < 8; k++) begin
      run_op((k + 3) % 4, rr_a[k], rr_b[k], 3 + k, 1'b0,
             (k < 7) ? (4'b1111 & ~(4'b0001 << ((k + 3) % 4))) : 4'b0000);
    end

    // Wrap and skip: ptr 3 -> grant 3 -> grant 1, then probes for ptr 2 and ptr 0.
    run_op(2, 16'h0011, 16'h0011, 2, 1'b0, 4'b0000);
    run_op(3, 16'h0101, 16'h0003, 4, 1'b0, 4'b0010);
    run_op(1, 16'h0202, 16'h0004, 1, 1'b0, 4'b0000);
    run_op(3, 16'h0033, 16'h0010, 5, 1'b0, 4'b0011);
    run_op(0, 16'h4000, 16'h0004, 6, 1'b0, 4'b0010);
    run_op(1, 16'h0009, 16'h0009, 3, 1'b0, 4'b0000);

    // Watchdog: hang, tie at TIMEOUT, one cycle late, one cycle early.
    run_op(2, 16'hBEEF, 16'h0003, 5, 1'b1, 4'b0000);
    run_op(3, 16'hFFFF, 16'hFFFF, TIMEOUT, 1'b0, 4'b0000);
    run_op(0, 16'h1111, 16'h0002, TIMEOUT + 1, 1'b0, 4'b0000);
    run_op(1, 16'h2222, 16'h0003, TIMEOUT - 1, 1'b0, 4'b0000);

    // Reset mid-WAIT (ptr is 2 now, requester 3 wins).
    mdl_lat   = 30;
    mdl_never = 1'b0;
    req_A[3*N +: N] = 16'h0077;
    req_B[3*N +: N] = 16'h0005;
    req_valid = 4'b1000;
    tick;
    req_valid = 4'b0000;
    repeat (6) tick;
    chk("wait_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_mul_start", 64'(mul_start), 64'd0);
    chk("arst_mul_A", 64'(mul_A), 64'd0);
    chk("arst_mul_B", 64'(mul_B), 64'd0);
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_rsp_prod", 64'(rsp_prod), 64'd0);
    chk("arst_rsp_err", 64'(rsp_err), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd0);
    repeat (3) tick;
    reset  = 1'b1;
    silent = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (rsp_valid != 4'b0000 || busy) silent++;
    end
    chk("aborted_no_rsp", 64'(silent), 64'd0);
    run_op(1, 16'h0500, 16'h0600, 8, 1'b0, 4'b1000);
    run_op(3, 16'h0003, 16'h0003, 2, 1'b0, 4'b0000);

    // Random regression.
    for (int i = 0; i < 100; i++) begin
      run_op(int'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
             int'($urandom_range(1, 20)), 1'b0, 4'b0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one `mult_serial` multiplier among `NREQ` requesters. It accepts one request at a time and launches the multiplier with a one-cycle start pulse. It waits for completion, supervised by a watchdog, and returns the product to the granted requester as a one-cycle response. It sits between the client blocks and the single `mult_serial` instance, and drives that instance's `start`, `A` and `B` ports.

## Interface
- `N`, 16: operand width; product width is 2N.
- `NREQ`, 4: number of requesters, ≥2.
- `TIMEOUT`, 64: maximum WAIT cycles before the operation is aborted, ≥2.
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: bit i set means requester i has a pending operation.
- `req_A` in NREQ*N: operand A of requester i at bits [i*N +: N].
- `req_B` in NREQ*N: operand B of requester i at bits [i*N +: N].
- `req_ready` out NREQ: one-hot accept; combinational from state, pointer and `req_valid`.
- `rsp_valid` out NREQ: one-hot, one-cycle response pulse to the granted requester.
- `rsp_prod` out 2N: product, valid while any `rsp_valid` bit is set.
- `rsp_err` out 1: watchdog abort flag, valid while any `rsp_valid` bit is set.
- `busy` out 1: high whenever the state is not IDLE.
- `mul_start` out 1: one-cycle start pulse to the multiplier.
- `mul_A` out N: operand A to the multiplier.
- `mul_B` out N: operand B to the multiplier.
- `mul_end` in 1: multiplier completion indication.
- `mul_produto` in 2N: multiplier product, valid when `mul_end` is high.

## Operation
- State machine states: IDLE, START, WAIT, RESP.
- **IDLE**
  - The winner is the first set bit of `req_valid` searching upward from `ptr`, wrapping modulo NREQ.
  - `req_ready[winner]` is 1; all other bits are 0. All bits are 0 if no request is pending.
  - On accept (`req_valid[i] & req_ready[i]`): register `req_A[i]`/`req_B[i]` into `mul_A`/`mul_B`, set `gnt <= i`, set `ptr <= (i+1) mod NREQ`, then go to START.
- **START**
  - `mul_start = 1` for exactly this cycle.
  - `mul_end` is ignored.
  - Clear the watchdog counter, then go to WAIT.
- **WAIT**
  - The watchdog counter increments every cycle.
  - If `mul_end` = 1: capture `mul_produto`, clear the error flag, go to RESP.
  - Else, if the counter reaches TIMEOUT: set the product register to 0 and the error flag to 1, go to RESP.
  - If `mul_end` and the timeout occur in the same cycle, `mul_end` wins and `rsp_err` = 0.
- **RESP**
  - `rsp_valid[gnt]` = 1, with the registered `rsp_prod` and `rsp_err`.
  - Go to IDLE.
  - No request is accepted in this cycle.
- **Operand hold:** `mul_A`/`mul_B` hold their value from START until the next accept.
- **Requester rules:**
  - A requester holds `req_valid` and its operands stable until accepted.
  - `req_valid` may be deasserted before acceptance without side effects.
- **Arithmetic:** the arbiter does no arithmetic. `rsp_prod` is `mul_produto` passed through unmodified at full 2N width. The watchdog counter is $clog2(TIMEOUT+1) bits wide and does not wrap.
- **Reset values** (asserted asynchronously; applies equally mid-operation):
  - State IDLE, `ptr` = 0, `gnt` = 0.
  - `mul_start` = 0, `mul_A` = 0, `mul_B` = 0.
  - `rsp_valid` = 0, `rsp_prod` = 0, `rsp_err` = 0, `busy` = 0.
  - An aborted operation produces no response.

## Timing
- Accept in cycle T:
  - `mul_start` is high in T+1.
  - WAIT begins in T+2.
  - If `mul_end` is first sampled high in cycle W, `rsp_valid` is high in W+1.
- Earliest next accept is W+2: RESP and the following IDLE evaluation are sequential.
- Timeout response:
  - Abort is decided in cycle T+1+TIMEOUT.
  - `rsp_valid` (with `rsp_err` = 1) is high in T+2+TIMEOUT.
- Throughput: one operation per (multiplier latency + 3) cycles.
- Fairness: with all requesters continuously active, grants rotate 0,1,…,NREQ-1,0. No requester waits more than NREQ-1 operations.

## Test plan
- **Single request:** requester 2 requests A=16'h1234, B=16'h0010; multiplier model ends after 17 cycles.
  - `req_ready` = 4'b0100 in the request cycle.
  - One `mul_start` pulse with `mul_A`=1234, `mul_B`=0010.
  - `rsp_valid` = 4'b0100 one cycle after `mul_end`.
  - `rsp_prod` = 32'h00012340, `rsp_err` = 0.
- **Round robin:** all four requesters held valid for 8 operations.
  - Grant order 0,1,2,3,0,1,2,3.
  - Each `rsp_prod` equals that requester's A*B.
- **Wrap and skip:** `ptr` = 3, only requesters 1 and 3 valid.
  - Grant 3, then grant 1.
  - `ptr` becomes 0, then 2.
- **Timeout:** multiplier model never asserts `mul_end`.
  - `rsp_valid` appears exactly TIMEOUT+1 cycles after `mul_start`.
  - `rsp_prod` = 0, `rsp_err` = 1.
- **Tie:** `mul_end` asserted in the same cycle the counter reaches TIMEOUT.
  - `rsp_err` = 0 and `rsp_prod` = the model product.
- **Reset mid-WAIT:** pull `reset` low during WAIT.
  - All outputs are 0 immediately, with no clock edge needed.
  - No `rsp_valid` pulse occurs for the aborted operation.
  - After release, a new request completes normally with grant from `ptr` = 0.
- **Random regression:** 100 random operand pairs across random requesters, checked against a reference A*B.
